// File: rtl/full_adder_4bits_pkg.sv
// Shared sizing constants for the registered 4-bit ripple-carry adder.
package full_adder_4bits_pkg;
    localparam int WIDTH = 4;
    localparam int SUM_W = WIDTH + 1;
endpackage

// File: rtl/full_adder_4bits_fa1.sv
// Single-bit full-adder cell, purely combinational; chained by full_adder_4bits.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic w_p;

    assign w_p  = a ^ b;
    assign s    = w_p ^ cin;
    assign cout = (a & b) | (cin & w_p);
endmodule

// File: rtl/full_adder_4bits.sv
// Registered 4-bit ripple-carry adder exposing the per-stage carry chain.
// Outputs follow the operands with one cycle of latency; no enable or handshake.
module full_adder_4bits
    import full_adder_4bits_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] Cin,
    output logic [SUM_W-1:0] SUM,
    output logic [WIDTH-1:0] Co
);
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_s;
    logic             w_cin_unused;
    logic [SUM_W-1:0] r_sum;
    logic [WIDTH-1:0] r_co;

    // Only Cin[0] feeds the chain; the upper bits are reserved.
    assign w_carry[0]   = Cin[0];
    assign w_cin_unused = ^Cin[WIDTH-1:1];

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        full_adder_1bit u_fa (
            .a    (A[i]),
            .b    (B[i]),
            .cin  (w_carry[i]),
            .s    (w_s[i]),
            .cout (w_carry[i+1])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= '0;
            r_co  <= '0;
        end else begin
            r_sum <= {w_carry[WIDTH], w_s};
            r_co  <= w_carry[WIDTH:1];
        end
    end

    assign SUM = r_sum;
    assign Co  = r_co;
endmodule

// File: tb/tb_full_adder_4bits.sv
// Bench for full_adder_4bits: directed steps plus randomized exhaustive sweep vs arithmetic model.
module tb_full_adder_4bits;
    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] Cin;
    logic [4:0] SUM;
    logic [3:0] Co;

    int checks;
    int failures;

    full_adder_4bits dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .Cin (Cin),
        .SUM (SUM),
        .Co  (Co)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: plain integer addition; carry out of stage i is whether the
    // low (i+1) bits of the operands plus carry-in overflow 2^(i+1).
    function automatic logic [4:0] model_sum(input int a, input int b, input int c0);
        return 5'(a + b + c0);
    endfunction

    function automatic logic [3:0] model_co(input int a, input int b, input int c0);
        logic [3:0] co;
        for (int i = 0; i < 4; i++) begin
            int m;
            m = 1 << (i + 1);
            co[i] = ((a % m) + (b % m) + c0) >= m;
        end
        return co;
    endfunction

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one operand set after a falling edge, sample #1 after the next rising edge.
    task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        @(negedge clk);
        A   = a;
        B   = b;
        Cin = c;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_check(input string tag, input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] c);
        apply(a, b, c);
        check({tag, "_sum"}, SUM, model_sum(int'(a), int'(b), int'(c[0])));
        check({tag, "_co"}, {1'b0, Co}, {1'b0, model_co(int'(a), int'(b), int'(c[0]))});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b0;
        A   = 4'd0;
        B   = 4'd0;
        Cin = 4'd0;

        // Load 7+9 so the asynchronous clear is visible against a nonzero value.
        apply(4'd7, 4'd9, 4'd0);
        check("pre_reset_sum", SUM, 5'd16);
        #1 rst = 1'b1;
        #1;
        check("rst_async_sum", SUM, 5'd0);
        check("rst_async_co", {1'b0, Co}, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_held_sum", SUM, 5'd0);
        check("rst_held_co", {1'b0, Co}, 5'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_release_sum", SUM, 5'd16);
        check("rst_release_co", {1'b0, Co}, 5'b01111);

        // Incrementing sweep with wrap, plus a mid-stream reset pulse between edges.
        for (int k = 0; k <= 16; k++) begin
            logic [3:0] kk;
            kk = 4'(k);
            apply_check("sweep", kk, kk, 4'd0);
            check("sweep_double", SUM, 5'(2 * (k % 16)));
            if (k == 5) begin
                check("sweep_k5_sum", SUM, 5'd10);
                check("sweep_k5_co", {1'b0, Co}, 5'b00101);
            end
            if (k == 8) begin
                check("sweep_k8_sum", SUM, 5'd16);
                check("sweep_k8_co", {1'b0, Co}, 5'b01000);
            end
            if (k == 10) begin
                rst = 1'b1;
                #1;
                check("midrst_sum", SUM, 5'd0);
                check("midrst_co", {1'b0, Co}, 5'd0);
                #1 rst = 1'b0;
                #1;
                check("midrst_after_release_sum", SUM, 5'd0);
            end
        end

        // Full carry ripple, maximum, reserved Cin bits.
        apply_check("ripple_b1", 4'd15, 4'd1, 4'd0);
        check("ripple_b1_const", SUM, 5'b10000);
        apply_check("ripple_cin", 4'd15, 4'd0, 4'd1);
        check("ripple_cin_co_const", {1'b0, Co}, 5'b01111);
        apply_check("max", 4'd15, 4'd15, 4'b0001);
        check("max_const", SUM, 5'd31);
        apply_check("cin_upper", 4'd0, 4'd0, 4'b1110);
        check("cin_upper_const", SUM, 5'd0);

        // Operand changes between edges must not reach the outputs.
        apply(4'd3, 4'd4, 4'd0);
        A = 4'd12;
        B = 4'd13;
        #2;
        check("between_edges_sum", SUM, 5'd7);
        check("between_edges_co", {1'b0, Co}, 5'd0);

        // Exhaustive A, B, Cin[0] with random reserved bits, one set per cycle.
        for (int n = 0; n < 512; n++) begin
            logic [3:0] a;
            logic [3:0] b;
            logic [3:0] c;
            a = 4'(n >> 5);
            b = 4'(n >> 1);
            c = {3'($urandom_range(0, 7)), 1'(n)};
            apply_check("exh", a, b, c);
            check("exh_carry_inv", {4'd0, SUM[4]}, {4'd0, Co[3]});
        end

        // Randomized back-to-back operands.
        for (int n = 0; n < 64; n++) begin
            apply_check("rand", 4'($urandom), 4'($urandom), 4'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/full_adder_4bits.md
Name: full_adder_4bits

Overview:
- Registered 4-bit ripple-carry adder built from four 1-bit full-adder cells.
- Adds A, B and a carry-in. Presents a 5-bit sum plus the per-stage carry chain, both registered on the clock.
- Used as a small arithmetic leaf in datapaths that need the sum and visibility of the internal carries.

Parameters:
- WIDTH, 4, operand width. Only 4 is supported. The port widths below follow from it.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- A  input  4  operand A, unsigned.
- B  input  4  operand B, unsigned.
- Cin  input  4  carry-in bus. Only Cin[0] is used as the stage-0 carry-in. Cin[3:1] are reserved and have no effect on any output.
- SUM  output  5  registered result, equal to A + B + Cin[0]. SUM[4] is the final carry-out.
- Co  output  4  registered per-stage carry-outs. Co[i] is the carry out of bit stage i.

Behaviour:
- Reset:
  - While rst=1, SUM=5'd0 and Co=4'd0, regardless of clk.
  - Clear is immediate on rst rising (asynchronous).
  - After rst falls, the first rising clk edge loads normally.
- Combinational core:
  - Stage i computes s_i = A[i]^B[i]^c_i and c_(i+1) = (A[i]&B[i]) | (c_i&(A[i]^B[i])).
  - c_0 = Cin[0].
- Output registers, on each rising clk edge with rst=0:
  - SUM <= {c_4, s_3, s_2, s_1, s_0}
  - Co <= {c_4, c_3, c_2, c_1}
- Invariants:
  - SUM[4] == Co[3] always, including during reset.
  - The full unsigned range is covered: max is 15+15+1 = 31 (SUM=5'b11111). No overflow or wrap is possible in SUM.
- Latency and throughput:
  - Latency is exactly 1 clock; a new operand set is accepted every cycle.
  - No handshake and no enable: the registers update every cycle.
- Input changes between edges have no effect on the outputs until the next rising edge.
- Reset asserted mid-stream: outputs clear immediately. The operand present at the first edge after release is the first one reflected.
- X/undefined inputs are not sanitised; they propagate.

Decomposition:
- Shared package: constant WIDTH=4 and SUM_W=WIDTH+1. No typedefs needed.
- One sub-module, full_adder_1bit:
  - Ports a, b, cin, s, cout; purely combinational.
  - Instantiated four times in a ripple chain.
- The top level holds the carry wiring and the two output registers.

Test Plan:
- Reset: assert rst with A=4'd7, B=4'd9 -> SUM=0 and Co=0 immediately and while held. Release rst -> next edge gives SUM=16, Co=4'b1111.
- Incrementing sweep:
  - Stimulus: A=B=k, Cin=0, k stepping 0..15 one per cycle, then wrapping to 0.
  - Response: SUM = 2k one cycle later, e.g. k=5 -> SUM=10 with Co=4'b0101; k=8 -> SUM=16 with Co=4'b1000.
  - On wrap to k=0: SUM=0, Co=0.
- Full carry ripple: A=15, B=1, Cin=0 -> SUM=5'b10000, Co=4'b1111. Then A=15, B=0, Cin[0]=1 -> same result.
- Maximum: A=15, B=15, Cin=4'b0001 -> SUM=31, Co=4'b1111. Cin=4'b1110 with A=B=0 -> SUM=0, Co=0 (upper Cin bits ignored).
- Exhaustive: all 512 combinations of A, B, Cin[0] with a random Cin[3:1]. Check SUM == A+B+Cin[0], Co matches a reference carry model, and SUM[4]==Co[3], each one cycle after apply.
- Async reset mid-stream: pulse rst between clock edges during the sweep -> outputs go to 0 without a clock edge. Sweep resumes correctly one cycle after release.
